load_store_unit: RTL and testbench

//  Sits between execute stage and DataMem (word-only, write posedge, read negedge).

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte/half/word accesses into word accesses on a DataMem
// that writes on posedge and updates its read data on negedge.
module load_store_unit #(
    parameter int unsigned MemWords   = 256,
    parameter bit          CheckRange = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_rw_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [32:0] AddrLimit = 33'(4 * MemWords);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merged_q, merged_d;

    logic        req_misaligned;
    logic        req_illegal;
    logic        req_out_of_range;
    logic        req_fault;

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] merged_word;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    // Request checks operate on the raw inputs so a fault is known at accept time.
    always_comb begin
        req_misaligned = ((funct3_i[1:0] == 2'd1) && addr_i[0]) ||
                         ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'b00));
        if (req_we_i) begin
            req_illegal = (funct3_i >= 3'd3);
        end else begin
            req_illegal = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
        end
        req_out_of_range = CheckRange && ({1'b0, addr_i} >= AddrLimit);
        req_fault        = req_misaligned || req_illegal || req_out_of_range;
    end

    always_comb begin
        byte_shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
        half_shifted = mem_rdata_i >> {addr_q[1], 4'b0000};
        load_byte    = byte_shifted[7:0];
        load_half    = half_shifted[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{load_byte[7]}}, load_byte};
            3'd1:    load_ext = {{16{load_half[15]}}, load_half};
            3'd4:    load_ext = {24'h0, load_byte};
            3'd5:    load_ext = {16'h0, load_half};
            default: load_ext = mem_rdata_i;
        endcase
    end

    // Read-modify-write: only the addressed lane is replaced.
    always_comb begin
        byte_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        half_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        case (funct3_q[1:0])
            2'd0: merged_word = (mem_rdata_i & ~byte_mask) |
                                ({24'h0, wdata_q[7:0]} << {addr_q[1:0], 3'b000});
            2'd1: merged_word = (mem_rdata_i & ~half_mask) |
                                ({16'h0, wdata_q[15:0]} << {addr_q[1], 4'b0000});
            default: merged_word = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        merged_d = merged_q;
        mem_rw_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    funct3_d = funct3_i;
                    we_d     = req_we_i;
                    fault_d  = req_fault;
                    rdata_d  = 32'h0;
                    if (req_fault) begin
                        state_d = StDone;
                    end else if (req_we_i && (funct3_i == 3'd2)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (we_q) begin
                    merged_d = merged_word;
                    state_d  = StWrite;
                end else begin
                    rdata_d = load_ext;
                    state_d = StDone;
                end
            end
            StWrite: begin
                // A reset landing in this cycle must not let a partial store through.
                mem_rw_o = !reset_i;
                state_d  = StDone;
            end
            StDone: begin
                rdata_d = 32'h0;
                fault_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'h0;
            merged_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign rdata_o     = rdata_q;
    assign fault_o     = fault_q;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = (funct3_q == 3'd2) ? wdata_q : merged_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural DataMem
// (write on posedge, read data updated on negedge).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    int          rw_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    load_store_unit #(.MemWords(256), .CheckRange(1'b1)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .req_valid_i(req_valid),
        .req_we_i   (req_we),
        .funct3_i   (funct3),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .rdata_o    (rdata),
        .fault_o    (fault),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rw_o   (mem_rw),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rw) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            rw_cnt <= rw_cnt + 1;
        end
    end

    always @(negedge clk) mem_rdata <= mem[mem_addr[9:2]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and checks latency, result, fault and store count.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_fault,
                          input int exp_lat, input int exp_rw);
        int cyc;
        int rw0;
        step();
        check_eq({tag, " idle_done"}, {31'h0, done}, 32'h0);
        check_eq({tag, " idle_rdata"}, rdata, 32'h0);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        rw0       = rw_cnt;
        step();
        req_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 10) begin
            step();
            cyc++;
        end
        check_eq({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, " rdata"}, rdata, exp_rdata);
        check_eq({tag, " fault"}, {31'h0, fault}, {31'h0, exp_fault});
        check_eq({tag, " mem_rw_cycles"}, 32'(rw_cnt - rw0), 32'(exp_rw));
    endtask

    logic exp_busy [6];
    logic exp_done [6];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1]    = 32'h8081_F2A3;
        mem[8]    = 32'h5566_7788;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'd0;
        addr      = 32'h0;
        wdata     = 32'h0;
        step();
        step();
        check_eq("reset busy", {31'h0, busy}, 32'h0);
        check_eq("reset done", {31'h0, done}, 32'h0);
        check_eq("reset rdata", rdata, 32'h0);
        check_eq("reset fault", {31'h0, fault}, 32'h0);
        check_eq("reset mem_rw", {31'h0, mem_rw}, 32'h0);
        rst = 1'b0;

        // Lane select and extension
        do_req("LB 0x4",  1'b0, 3'd0, 32'h4, 32'h0, 32'hFFFF_FFA3, 1'b0, 2, 0);
        do_req("LBU 0x7", 1'b0, 3'd4, 32'h7, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
        do_req("LH 0x6",  1'b0, 3'd1, 32'h6, 32'h0, 32'hFFFF_8081, 1'b0, 2, 0);
        do_req("LHU 0x4", 1'b0, 3'd5, 32'h4, 32'h0, 32'h0000_F2A3, 1'b0, 2, 0);
        do_req("LB 0x5",  1'b0, 3'd0, 32'h5, 32'h0, 32'hFFFF_FFF2, 1'b0, 2, 0);

        // Word store and readback
        do_req("SW 0x10", 1'b1, 3'd2, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 2, 1);
        do_req("LW 0x10", 1'b0, 3'd2, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 2, 0);

        // Sub-word read-modify-write
        do_req("SB 0x11", 1'b1, 3'd0, 32'h11, 32'hFFFF_FFAA, 32'h0, 1'b0, 3, 1);
        do_req("SH 0x12", 1'b1, 3'd1, 32'h12, 32'h1111_BEEF, 32'h0, 1'b0, 3, 1);
        do_req("LW 0x10 merged", 1'b0, 3'd2, 32'h10, 32'h0, 32'hBEEF_AA78, 1'b0, 2, 0);

        // Faults
        do_req("LW 0x2 misaligned", 1'b0, 3'd2, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("SH 0x5 misaligned", 1'b1, 3'd1, 32'h5, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0);
        do_req("load f3=3",         1'b0, 3'd3, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("store f3=4",        1'b1, 3'd4, 32'h4, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0);
        do_req("LW 0x400 range",    1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("LW 0x3FC in range", 1'b0, 3'd2, 32'h3FC, 32'h0, 32'h0, 1'b0, 2, 0);
        check_eq("mem[0] unchanged", mem[0], 32'h0);
        check_eq("mem[1] unchanged", mem[1], 32'h8081_F2A3);
        check_eq("mem[4] unchanged", mem[4], 32'hBEEF_AA78);

        // Reset during WRITE of an SB
        step();
        req_valid = 1'b1;
        req_we    = 1'b1;
        funct3    = 3'd0;
        addr      = 32'h20;
        wdata     = 32'h0000_0011;
        step();
        req_valid = 1'b0;
        step();
        check_eq("rst_wr in WRITE mem_rw", {31'h0, mem_rw}, 32'h1);
        rst = 1'b1;
        #1;
        check_eq("rst_wr mem_rw suppressed", {31'h0, mem_rw}, 32'h0);
        step();
        rst = 1'b0;
        check_eq("rst_wr busy", {31'h0, busy}, 32'h0);
        check_eq("rst_wr done", {31'h0, done}, 32'h0);
        step();
        check_eq("rst_wr no late done", {31'h0, done}, 32'h0);
        check_eq("rst_wr mem[8]", mem[8], 32'h5566_7788);

        // Back-to-back LW with req_valid held high
        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_done = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = 3'd2;
        addr      = 32'h10;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 4) req_valid = 1'b0;
            check_eq($sformatf("b2b busy[%0d]", i), {31'h0, busy}, {31'h0, exp_busy[i]});
            check_eq($sformatf("b2b done[%0d]", i), {31'h0, done}, {31'h0, exp_done[i]});
            if (exp_done[i]) check_eq($sformatf("b2b rdata[%0d]", i), rdata, 32'hBEEF_AA78);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
